// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// cpu_defs : shared state encoding and instruction-field constants for fetch
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_HALT  = 6'h3F;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // Word-scaled, sign-extended branch displacement relative to pc+4.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    logic [31:0] sext;
    sext = {{16{imm[15]}}, imm};
    return pc_plus4 + (sext << 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_next_pc_select.sv
// ============================================================================
// next_pc_select : combinational next-PC candidate mux and fetch-fault check
// Revision       : 1.0
// ============================================================================
`default_nettype none

module next_pc_select
  import cpu_defs::*;
#(
  parameter int IMEM_BYTES = 256
) (
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] instr_index_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        jump_reg_i,
  input  logic [31:0] reg_target_i,
  output logic [31:0] candidate_o,
  output logic        fault_o
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  assign branch_tgt = branch_target(pc_plus4_i, instr_index_i[IMM_MSB:IMM_LSB]);
  assign jump_tgt   = {pc_plus4_i[31:28], instr_index_i[TARGET_MSB:TARGET_LSB], 2'b00};

  always_comb begin
    candidate_o = pc_plus4_i;
    if (jump_reg_i) begin
      candidate_o = reg_target_i;
    end else if (jump_i) begin
      candidate_o = jump_tgt;
    end else if (branch_taken_i) begin
      candidate_o = branch_tgt;
    end
  end

  assign fault_o = (candidate_o[1:0] != 2'b00) || (candidate_o > PC_MAX);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : PC register, fetch-control FSM and retired-instruction count
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_BYTES  = 256,
  parameter logic [5:0]  HALT_OPCODE = OPC_HALT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic [31:0] regTarget,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchValid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  candidate;
  logic         candidate_fault;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_select #(
    .IMEM_BYTES(IMEM_BYTES)
  ) u_next_pc_select (
    .pc_plus4_i     (pc_plus4),
    .instr_index_i  (instruction[TARGET_MSB:TARGET_LSB]),
    .branch_taken_i (branchTaken),
    .jump_i         (jump),
    .jump_reg_i     (jumpReg),
    .reg_target_i   (regTarget),
    .candidate_o    (candidate),
    .fault_o        (candidate_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // HALT counts as a completed instruction; a faulting fetch does not.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (instruction[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
            state_d   = ST_HALT;
            retired_d = retired_q + 32'd1;
          end else if (candidate_fault) begin
            state_d = ST_FAULT;
          end else begin
            pc_d      = candidate;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign fetchValid = (state_q == ST_RUN);
  assign halted     = (state_q == ST_HALT);
  assign fault      = (state_q == ST_FAULT);
  assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded directed bench for pc_fetch_unit: stimulus queues expected
// outputs, a monitor compares them after each clock edge or immediate probe.
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        stall;
  logic        branchTaken;
  logic        jump;
  logic        jumpReg;
  logic [31:0] regTarget;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fv;
    logic        h;
    logic        f;
    logic [31:0] ret;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_total  = 0;
  int    n_passed = 0;
  event  probe_ev;

  localparam logic [31:0] HALT_INS = 32'hFC00_0000;
  localparam logic [31:0] J_INS    = 32'h0800_0010;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruction(instruction),
    .stall      (stall),
    .branchTaken(branchTaken),
    .jump       (jump),
    .jumpReg    (jumpReg),
    .regTarget  (regTarget),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .fetchValid (fetchValid),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // Monitor: one pending expectation is retired per clock edge or probe.
  initial begin
    exp_t  e;
    exp_t  a;
    string n;
    forever begin
      @(posedge clk or probe_ev);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n = name_q.pop_front();
        a = '{pc: pc, pc4: pcPlus4, fv: fetchValid, h: halted, f: fault, ret: retired};
        n_total++;
        if (a === e) begin
          n_passed++;
        end else begin
          $display("FAIL %s: got pc=%h pc4=%h fv=%b h=%b f=%b ret=%0d, want pc=%h pc4=%h fv=%b h=%b f=%b ret=%0d",
                   n, a.pc, a.pc4, a.fv, a.h, a.f, a.ret, e.pc, e.pc4, e.fv, e.h, e.f, e.ret);
        end
      end
    end
  end

  task automatic set_in(input logic [31:0] ins, input logic st, input logic br,
                        input logic j, input logic jr, input logic [31:0] rt);
    instruction = ins;
    stall       = st;
    branchTaken = br;
    jump        = j;
    jumpReg     = jr;
    regTarget   = rt;
  endtask

  task automatic expect_st(input string n, input logic [31:0] epc, input logic efv,
                           input logic eh, input logic ef, input logic [31:0] eret);
    exp_t e;
    e = '{pc: epc, pc4: epc + 32'd4, fv: efv, h: eh, f: ef, ret: eret};
    sb_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Immediate (edge-free) probe of the current outputs.
  task automatic probe(input string n, input logic [31:0] epc, input logic efv,
                       input logic eh, input logic ef, input logic [31:0] eret);
    expect_st(n, epc, efv, eh, ef, eret);
    -> probe_ev;
    #2;
  endtask

  // Drive inputs for one cycle and queue the state expected after its edge.
  task automatic drv(input string n, input logic [31:0] ins, input logic st,
                     input logic br, input logic j, input logic jr,
                     input logic [31:0] rt, input logic [31:0] epc,
                     input logic efv, input logic eh, input logic ef,
                     input logic [31:0] eret);
    @(negedge clk);
    set_in(ins, st, br, j, jr, rt);
    expect_st(n, epc, efv, eh, ef, eret);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    probe("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Release: BOOT ignores controls for one cycle.
    @(negedge clk);
    rst_n = 1'b1;
    set_in(J_INS, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    probe("boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_st("boot_to_run", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);

    drv("seq4",  32'h0, 0, 0, 0, 0, 32'h0, 32'd4,  1, 0, 0, 32'd1);
    drv("seq8",  32'h0, 0, 0, 0, 0, 32'h0, 32'd8,  1, 0, 0, 32'd2);
    drv("seq12", 32'h0, 0, 0, 0, 0, 32'h0, 32'd12, 1, 0, 0, 32'd3);

    drv("jr_to8",    32'h0,        0, 0, 0, 1, 32'd8, 32'd8,  1, 0, 0, 32'd4);
    drv("br_neg",    32'h0000_FFFE, 0, 1, 0, 0, 32'h0, 32'd4,  1, 0, 0, 32'd5);
    drv("jr_to8b",   32'h0,        0, 0, 0, 1, 32'd8, 32'd8,  1, 0, 0, 32'd6);
    drv("br_pos",    32'h0000_0003, 0, 1, 0, 0, 32'h0, 32'd24, 1, 0, 0, 32'd7);
    drv("jr_to16",   32'h0,        0, 0, 0, 1, 32'd16, 32'd16, 1, 0, 0, 32'd8);
    drv("j_over_br", J_INS,        0, 1, 1, 0, 32'h0, 32'd64, 1, 0, 0, 32'd9);
    drv("jr_over_all", J_INS,      0, 1, 1, 1, 32'h20, 32'd32, 1, 0, 0, 32'd10);
    drv("jr_to12",   32'h0,        0, 0, 0, 1, 32'd12, 32'd12, 1, 0, 0, 32'd11);

    for (int i = 0; i < 3; i++) begin
      drv("stall", J_INS, 1, 0, 1, 0, 32'h0, 32'd12, 1, 0, 0, 32'd11);
    end
    drv("stall_halt", HALT_INS, 1, 0, 0, 0, 32'h0, 32'd12, 1, 0, 0, 32'd11);
    drv("halt",       HALT_INS, 0, 0, 0, 0, 32'h0, 32'd12, 0, 1, 0, 32'd12);
    drv("halt_hold",  32'h0,    0, 0, 0, 1, 32'h0, 32'd12, 0, 1, 0, 32'd12);

    // Asynchronous reset mid-cycle while halted.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    probe("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    probe("boot2", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_st("run2", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    drv("seq4_again", 32'h0, 0, 0, 0, 0, 32'h0, 32'd4, 1, 0, 0, 32'd1);
    drv("fault_misal", 32'h0, 0, 0, 0, 1, 32'h22, 32'd4, 0, 0, 1, 32'd1);
    drv("fault_hold",  J_INS, 0, 0, 1, 0, 32'h0,  32'd4, 0, 0, 1, 32'd1);

    @(negedge clk);
    rst_n = 1'b0;
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    probe("reset3", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_st("run3", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    drv("jr_lastword", 32'h0, 0, 0, 0, 1, 32'hFC,  32'hFC, 1, 0, 0, 32'd1);
    drv("fault_oob",   32'h0, 0, 0, 0, 1, 32'h100, 32'hFC, 0, 0, 1, 32'd1);
    drv("fault_jump",  J_INS, 0, 0, 1, 0, 32'h0,   32'hFC, 0, 0, 1, 32'd1);
    drv("fault_nohalt", HALT_INS, 0, 0, 0, 0, 32'h0, 32'hFC, 0, 0, 1, 32'd1);

    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (sb_q.size() == 0) begin
      n_passed++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage directly upstream of the instruction memory. Holds the PC, drives the byte address into instruction memory, and selects the next PC each cycle. Next-PC sources are sequential, branch, jump and jump-register. Also handles stalls, HALT detection, fetch faults and a retired-instruction counter for the single-cycle CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 256, instruction memory size in bytes; legal PCs are 0 to IMEM_BYTES-4.
HALT_OPCODE, 6'h3F, opcode field (instruction[31:26]) that stops fetch.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
instruction  input  32  word returned by instruction memory for the current pc.
stall  input  1  hold the PC this cycle.
branchTaken  input  1  take the branch; target is pcPlus4 + (sext(instruction[15:0]) << 2).
jump  input  1  J-type jump; target is {pcPlus4[31:28], instruction[25:0], 2'b00}.
jumpReg  input  1  jump to regTarget.
regTarget  input  32  register-sourced target for jumpReg.
pc  output  32  current PC; drives instruction-memory readAddress.
pcPlus4  output  32  pc + 4, for link and branch logic.
fetchValid  output  1  instruction is a live instruction this cycle.
halted  output  1  sticky HALT indication.
fault  output  1  sticky fetch-fault indication.
retired  output  32  count of instructions completed.

Behaviour:
- Reset, asynchronous on rst_n low: state=BOOT, pc=RESET_PC, halted=0, fault=0, retired=0, fetchValid=0. Reset mid-operation aborts everything, including HALT and FAULT.
- States:
  - BOOT: lasts one cycle after reset release. PC is held; fetchValid=0. Always moves to RUN, giving the instruction memory one settle cycle.
  - RUN: fetchValid=1.
  - HALT: fetchValid=0; pc frozen; halted=1.
  - FAULT: fetchValid=0; pc frozen; fault=1.
  - HALT and FAULT are left only by reset.
- RUN next-PC priority, highest first:
  1. stall=1: pc held; retired unchanged; no HALT check.
  2. instruction[31:26]==HALT_OPCODE: go to HALT; pc held; retired+1.
  3. jumpReg: candidate = regTarget.
  4. jump: candidate = jump target.
  5. branchTaken: candidate = branch target.
  6. Otherwise: candidate = pcPlus4.
- Fault check on candidate: if candidate[1:0]!=0 or candidate > IMEM_BYTES-4, go to FAULT. pc keeps the offending instruction's address; retired unchanged.
- Otherwise pc <= candidate and retired <= retired+1. One-cycle latency: the new pc is visible after the clock edge.
- Arithmetic: all adds are 32-bit modulo 2^32. Branch offset is sign-extended to 32 bits before the shift. retired wraps at 2^32-1 → 0.
- pcPlus4 is combinational from pc in every state.
- Control inputs are ignored outside RUN.

Decomposition:
- Shared package `cpu_defs`:
  - state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2, FAULT=2'd3);
  - opcode field constants, including HALT_OPCODE;
  - instruction field bit positions (OPCODE 31:26, IMM 15:0, TARGET 25:0).
- One natural sub-module: `next_pc_select`. It is purely combinational, computes candidate and the fault flag, and is reusable by a later pipelined fetch.
- The state register and counters stay in pc_fetch_unit.

Test Plan:
1. Reset release, instruction=32'h0, no controls → BOOT for 1 cycle (fetchValid=0), then pc sequence 0,4,8,12; retired=3 after the 3rd RUN edge.
2. pc=8, branchTaken=1, instruction[15:0]=16'hFFFE → pc=4 (8+4-8); with imm=16'h0003 → pc=24.
3. pc=16, jump=1 and branchTaken=1 together, instruction[25:0]=26'h10 → pc=64 (jump wins). jumpReg=1, regTarget=32'h20 in the same cycle → pc=32 (jumpReg wins).
4. Stall=1 for 3 cycles at pc=12 → pc stays 12 and retired is unchanged. Stall together with a HALT opcode → no halt; deassert stall → halted=1, pc=12, fetchValid=0.
5. jumpReg with regTarget=32'h22 → fault=1, pc unchanged. Separately, regTarget=32'h100 (= IMEM_BYTES) → fault. A further jump attempt leaves pc frozen.
6. Assert rst_n=0 asynchronously mid-cycle while halted → halted=0, pc=0 immediately without a clock edge; normal fetch resumes after BOOT.
